// File: rtl/dmi_pkg.sv
// Shared DMI definitions: opcode and response encodings, default field widths,
// the request record carried through the bridge, and the bridge FSM states.
package dmi_pkg;

    localparam int DMI_ADDR_W = 7;
    localparam int DMI_DATA_W = 32;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;
    localparam logic [1:0] DMI_OP_RSVD  = 2'd3;

    localparam logic [1:0] DMI_RESP_SUCCESS = 2'd0;
    localparam logic [1:0] DMI_RESP_RSVD    = 2'd1;
    localparam logic [1:0] DMI_RESP_FAILED  = 2'd2;
    localparam logic [1:0] DMI_RESP_BUSY    = 2'd3;

    typedef struct packed {
        logic [DMI_ADDR_W-1:0] addr;
        logic [1:0]            op;
        logic [DMI_DATA_W-1:0] data;
    } dmi_req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RETURN
    } bridge_state_e;

endpackage

// File: rtl/dmi_req_fifo.sv
// Request FIFO: DEPTH entries of registered storage, with read/write pointers
// that carry one extra wrap bit so full and empty can be told apart.
module dmi_req_fifo
    import dmi_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = dmi_req_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    entry_t         mem_q [DEPTH];
    entry_t         mem_d [DEPTH];
    logic [PTR_W:0] wr_ptr_q;
    logic [PTR_W:0] wr_ptr_d;
    logic [PTR_W:0] rd_ptr_q;
    logic [PTR_W:0] rd_ptr_d;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    // Store a pushed entry at the tail and advance whichever pointers moved.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !full) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_data;
            wr_ptr_d                   = wr_ptr_q + PTR_ONE;
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // Storage and pointer registers; reset discards all queued requests.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/dmi_retry_bridge.sv
// DMI retry bridge: queues transport requests, issues them to the debug module
// one at a time, silently re-issues BUSY answers up to MAX_RETRY times, and
// returns exactly one response per request in order.
module dmi_retry_bridge
    import dmi_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_RETRY = 8,
    parameter int ADDR_W    = DMI_ADDR_W,
    parameter int DATA_W    = DMI_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dtm_req_valid,
    output logic              dtm_req_ready,
    input  logic [ADDR_W-1:0] dtm_req_addr,
    input  logic [1:0]        dtm_req_op,
    input  logic [DATA_W-1:0] dtm_req_data,
    output logic              dtm_resp_valid,
    input  logic              dtm_resp_ready,
    output logic [1:0]        dtm_resp_resp,
    output logic [DATA_W-1:0] dtm_resp_data,
    output logic              dm_req_valid,
    input  logic              dm_req_ready,
    output logic [ADDR_W-1:0] dm_req_addr,
    output logic [1:0]        dm_req_op,
    output logic [DATA_W-1:0] dm_req_data,
    input  logic              dm_resp_valid,
    output logic              dm_resp_ready,
    input  logic [1:0]        dm_resp_resp,
    input  logic [DATA_W-1:0] dm_resp_data,
    output logic [7:0]        retry_count,
    output logic              busy_err
);
    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [1:0]        op;
        logic [DATA_W-1:0] data;
    } req_t;

    req_t          fifo_in;
    req_t          fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_pop;

    bridge_state_e     state_q, state_d;
    logic [7:0]        retry_count_q, retry_count_d;
    logic              busy_err_q, busy_err_d;
    logic [1:0]        resp_q, resp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              dm_req_valid_q, dm_req_valid_d;
    logic              dm_resp_ready_q, dm_resp_ready_d;
    logic              dtm_resp_valid_q, dtm_resp_valid_d;

    assign dtm_req_ready = reset & ~fifo_full;
    assign fifo_in       = '{addr: dtm_req_addr, op: dtm_req_op, data: dtm_req_data};

    dmi_req_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (req_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (dtm_req_valid & dtm_req_ready),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign dm_req_addr    = fifo_head.addr;
    assign dm_req_op      = fifo_head.op;
    assign dm_req_data    = fifo_head.data;
    assign dm_req_valid   = dm_req_valid_q;
    assign dm_resp_ready  = dm_resp_ready_q;
    assign dtm_resp_valid = dtm_resp_valid_q;
    assign dtm_resp_resp  = resp_q;
    assign dtm_resp_data  = rdata_q;
    assign retry_count    = retry_count_q;
    assign busy_err       = busy_err_q;

    // Next-state logic: the head entry is only popped once its final answer is captured,
    // so a BUSY retry re-presents the very same request.
    always_comb begin
        state_d       = state_q;
        retry_count_d = retry_count_q;
        busy_err_d    = busy_err_q;
        resp_d        = resp_q;
        rdata_d       = rdata_q;
        fifo_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d       = ST_ISSUE;
                    retry_count_d = '0;
                end
            end
            ST_ISSUE: begin
                if (dm_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dm_resp_valid) begin
                    if ((dm_resp_resp == DMI_RESP_BUSY) && (retry_count_q < RETRY_LIMIT)) begin
                        retry_count_d = retry_count_q + 8'd1;
                        state_d       = ST_ISSUE;
                    end else begin
                        if (dm_resp_resp == DMI_RESP_BUSY) begin
                            busy_err_d = 1'b1;
                        end
                        resp_d   = dm_resp_resp;
                        rdata_d  = dm_resp_data;
                        fifo_pop = 1'b1;
                        state_d  = ST_RETURN;
                    end
                end
            end
            ST_RETURN: begin
                if (dtm_resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        dm_req_valid_d   = (state_d == ST_ISSUE);
        dm_resp_ready_d  = (state_d == ST_WAIT);
        dtm_resp_valid_d = (state_d == ST_RETURN);
    end

    // FSM, retry counter, response register and sticky error, with registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            retry_count_q    <= '0;
            busy_err_q       <= 1'b0;
            resp_q           <= '0;
            rdata_q          <= '0;
            dm_req_valid_q   <= 1'b0;
            dm_resp_ready_q  <= 1'b0;
            dtm_resp_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            retry_count_q    <= retry_count_d;
            busy_err_q       <= busy_err_d;
            resp_q           <= resp_d;
            rdata_q          <= rdata_d;
            dm_req_valid_q   <= dm_req_valid_d;
            dm_resp_ready_q  <= dm_resp_ready_d;
            dtm_resp_valid_q <= dtm_resp_valid_d;
        end
    end

endmodule

// File: tb/tb_dmi_retry_bridge.sv
// Testbench for dmi_retry_bridge: a transport driver, a debug-module responder
// that answers each request from a per-request plan (number of BUSY answers,
// then a final code), and a transport-side monitor that compares every response
// against the outcome the retry rules predict for that plan.
module tb_dmi_retry_bridge;
    import dmi_pkg::*;

    localparam int MAX_RETRY = 3;
    localparam int DEPTH     = 4;

    typedef struct {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
        int          busyCnt;
        logic [1:0]  finalResp;
        logic [31:0] finalData;
        logic [31:0] busyData;
    } tb_req_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        dtm_req_valid, dtm_req_ready;
    logic [6:0]  dtm_req_addr;
    logic [1:0]  dtm_req_op;
    logic [31:0] dtm_req_data;
    logic        dtm_resp_valid, dtm_resp_ready;
    logic [1:0]  dtm_resp_resp;
    logic [31:0] dtm_resp_data;
    logic        dm_req_valid, dm_req_ready;
    logic [6:0]  dm_req_addr;
    logic [1:0]  dm_req_op;
    logic [31:0] dm_req_data;
    logic        dm_resp_valid, dm_resp_ready;
    logic [1:0]  dm_resp_resp;
    logic [31:0] dm_resp_data;
    logic [7:0]  retry_count;
    logic        busy_err;

    int      checkCount = 0;
    int      errorCount = 0;
    tb_req_t pendQ[$];
    int      curAttempts = 0;
    bit      busyErrExp  = 0;
    bit      dmStall     = 0;
    bit      dmRespHold  = 0;
    bit      holdResp    = 0;

    dmi_retry_bridge #(.DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY), .ADDR_W(7), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .dtm_req_valid(dtm_req_valid), .dtm_req_ready(dtm_req_ready),
        .dtm_req_addr(dtm_req_addr), .dtm_req_op(dtm_req_op), .dtm_req_data(dtm_req_data),
        .dtm_resp_valid(dtm_resp_valid), .dtm_resp_ready(dtm_resp_ready),
        .dtm_resp_resp(dtm_resp_resp), .dtm_resp_data(dtm_resp_data),
        .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready),
        .dm_req_addr(dm_req_addr), .dm_req_op(dm_req_op), .dm_req_data(dm_req_data),
        .dm_resp_valid(dm_resp_valid), .dm_resp_ready(dm_resp_ready),
        .dm_resp_resp(dm_resp_resp), .dm_resp_data(dm_resp_data),
        .retry_count(retry_count), .busy_err(busy_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic tb_req_t makeReq(input logic [6:0] addr, input logic [1:0] op, input logic [31:0] data,
                                        input int busyCnt, input logic [1:0] finalResp, input logic [31:0] finalData);
        tb_req_t r;
        r.addr = addr; r.op = op; r.data = data; r.busyCnt = busyCnt;
        r.finalResp = finalResp; r.finalData = finalData; r.busyData = $urandom;
        return r;
    endfunction

    function automatic tb_req_t randomReq();
        int b;
        b = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0;
        return makeReq(7'($urandom), 2'($urandom), $urandom, b, 2'($urandom_range(0, 2)), $urandom);
    endfunction

    // Offer one request to the bridge and hold it until accepted (bounded).
    task automatic applyStimulus(input tb_req_t r);
        int waited = 0;
        @(negedge clk);
        dtm_req_valid = 1'b1;
        dtm_req_addr  = r.addr;
        dtm_req_op    = r.op;
        dtm_req_data  = r.data;
        while (!dtm_req_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!dtm_req_ready) begin
            checkOutput("pushTimeout", 64'(waited), 0);
        end else begin
            pendQ.push_back(r);
            @(posedge clk);
        end
        #1 dtm_req_valid = 1'b0;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (pendQ.size() > 0 && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        if (pendQ.size() > 0) begin
            checkOutput("drainTimeout", 64'(pendQ.size()), 0);
            pendQ.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Debug-module model: accepts requests, answers per the head request's plan after a short delay,
    // and occasionally raises a stray response while no request is outstanding.
    initial begin : dmResponder
        int          phase = 0;
        int          delay = 0;
        bit          terminating = 0;
        bit          checkLatency = 0;
        logic [1:0]  respCode = 0;
        logic [31:0] respData = 0;
        tb_req_t     cur;
        dm_req_ready = 0; dm_resp_valid = 0; dm_resp_resp = 0; dm_resp_data = 0;
        forever begin
            @(negedge clk);
            if (checkLatency) begin
                checkOutput("respLatency", 64'(dtm_resp_valid), 1);
                checkLatency = 0;
            end
            if (!reset) begin
                phase = 0; dm_req_ready = 0; dm_resp_valid = 0;
            end else if (phase == 0) begin
                dm_req_ready  = !dmStall && ($urandom_range(0, 3) != 0);
                dm_resp_valid = ($urandom_range(0, 7) == 0);
                dm_resp_resp  = DMI_RESP_BUSY;
                dm_resp_data  = $urandom;
                if (dm_req_valid && dm_req_ready) begin
                    if (pendQ.size() == 0) begin
                        checkOutput("reqWithoutPush", 1, 0);
                    end else begin
                        cur = pendQ[0];
                        checkOutput("reqFields", {dm_req_addr, dm_req_op, dm_req_data}, {cur.addr, cur.op, cur.data});
                        checkOutput("issueRetryCount", 64'(retry_count), 64'(curAttempts));
                        checkOutput("attemptLimit", 64'(curAttempts <= MAX_RETRY), 1);
                        if (curAttempts < cur.busyCnt) begin
                            respCode = DMI_RESP_BUSY; respData = cur.busyData;
                        end else begin
                            respCode = cur.finalResp; respData = cur.finalData;
                        end
                        terminating = (respCode != DMI_RESP_BUSY) || (curAttempts >= MAX_RETRY);
                        curAttempts++;
                        delay = $urandom_range(0, 2);
                        phase = 1;
                    end
                end
            end else begin
                dm_req_ready = 0;
                if (dmRespHold || delay > 0) begin
                    dm_resp_valid = 0;
                    if (delay > 0) delay--;
                end else begin
                    dm_resp_valid = 1;
                    dm_resp_resp  = respCode;
                    dm_resp_data  = respData;
                    if (dm_resp_ready) begin
                        phase = 0;
                        checkLatency = terminating;
                    end
                end
            end
        end
    end

    // Transport-side monitor: every accepted response must match the oldest outstanding request's outcome.
    initial begin : dtmMonitor
        tb_req_t r;
        bit      exhausted;
        int      expRetry;
        dtm_resp_ready = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                dtm_resp_ready = 0;
            end else begin
                dtm_resp_ready = !holdResp && ($urandom_range(0, 3) != 0);
                if (dtm_resp_valid && dtm_resp_ready) begin
                    if (pendQ.size() == 0) begin
                        checkOutput("unexpectedResp", 1, 0);
                    end else begin
                        r         = pendQ.pop_front();
                        exhausted = (r.busyCnt > MAX_RETRY);
                        expRetry  = exhausted ? MAX_RETRY : r.busyCnt;
                        if (exhausted) busyErrExp = 1;
                        checkOutput("respCode", 64'(dtm_resp_resp), exhausted ? 64'(DMI_RESP_BUSY) : 64'(r.finalResp));
                        checkOutput("respData", 64'(dtm_resp_data), exhausted ? 64'(r.busyData) : 64'(r.finalData));
                        checkOutput("respRetryCount", 64'(retry_count), 64'(expRetry));
                        checkOutput("dmHandshakes", 64'(curAttempts), 64'(expRetry + 1));
                        checkOutput("busyErr", 64'(busy_err), 64'(busyErrExp));
                        curAttempts = 0;
                    end
                end
            end
        end
    end

    initial begin : mainSeq
        tb_req_t reqA;
        int      waited;
        int      strays;
        reset = 1; dtm_req_valid = 0; dtm_req_addr = 0; dtm_req_op = 0; dtm_req_data = 0;
        #3 reset = 0;
        #1;
        checkOutput("rstReqReady", 64'(dtm_req_ready), 0);
        checkOutput("rstOutputs", {dtm_resp_valid, dm_req_valid, dm_resp_ready, busy_err, retry_count}, 0);
        repeat (3) @(negedge clk);
        #2 reset = 1;
        @(negedge clk);
        checkOutput("readyAfterRst", 64'(dtm_req_ready), 1);

        $display("[TB] single read, immediate success");
        applyStimulus(makeReq(7'h11, DMI_OP_READ, 32'h0, 0, DMI_RESP_SUCCESS, 32'hDEADBEEF));
        waitDrain(200);

        $display("[TB] write answered BUSY three times then success");
        applyStimulus(makeReq(7'h10, DMI_OP_WRITE, 32'h1, 3, DMI_RESP_SUCCESS, 32'h0));
        waitDrain(300);

        $display("[TB] debug module always BUSY");
        applyStimulus(makeReq(7'h22, DMI_OP_READ, 32'h0, 100, DMI_RESP_SUCCESS, 32'h0));
        waitDrain(300);
        checkOutput("busyErrSticky", 64'(busy_err), 1);

        $display("[TB] fill FIFO while debug module stalled");
        dmStall = 1;
        for (int i = 0; i < DEPTH; i++) applyStimulus(randomReq());
        @(negedge clk);
        checkOutput("fullReady", 64'(dtm_req_ready), 0);
        repeat (5) @(negedge clk);
        checkOutput("fullReadyHeld", 64'(dtm_req_ready), 0);
        dmStall = 0;
        applyStimulus(randomReq());
        waitDrain(1000);

        $display("[TB] transport withholds response ready");
        holdResp = 1;
        reqA = makeReq(7'h05, DMI_OP_READ, 32'h0, 0, DMI_RESP_FAILED, 32'h0BADF00D);
        applyStimulus(reqA);
        applyStimulus(randomReq());
        waited = 0;
        while (!dtm_resp_valid && waited < 200) begin @(negedge clk); waited++; end
        checkOutput("holdRespArrived", 64'(dtm_resp_valid), 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("holdStable", {dtm_resp_valid, dtm_resp_resp, dtm_resp_data}, {1'b1, reqA.finalResp, reqA.finalData});
            checkOutput("holdNoIssue", 64'(dm_req_valid), 0);
        end
        holdResp = 0;
        waitDrain(500);

        $display("[TB] reset while waiting on the debug module");
        dmRespHold = 1;
        for (int i = 0; i < 3; i++) applyStimulus(randomReq());
        waited = 0;
        while (!dm_resp_ready && waited < 200) begin @(negedge clk); waited++; end
        checkOutput("reachedWait", 64'(dm_resp_ready), 1);
        @(negedge clk);
        #2 reset = 0;
        #1;
        checkOutput("midRstOutputs", {dtm_req_ready, dtm_resp_valid, dm_req_valid, dm_resp_ready, busy_err, retry_count}, 0);
        pendQ.delete();
        curAttempts = 0;
        busyErrExp  = 0;
        dmRespHold  = 0;
        repeat (3) @(negedge clk);
        #2 reset = 1;
        strays = 0;
        repeat (8) begin
            @(negedge clk);
            if (dtm_resp_valid || dm_req_valid) strays++;
        end
        checkOutput("noRespAfterRst", 64'(strays), 0);
        applyStimulus(makeReq(7'h33, DMI_OP_WRITE, 32'hCAFE0001, 1, DMI_RESP_SUCCESS, 32'h12345678));
        waitDrain(300);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 60; i++) applyStimulus(randomReq());
        waitDrain(20000);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
